wait_memory: RTL and testbench

WAIT_MEMORY -- requirements
Module: wait_memory

---
 rtl/wait_memory.sv | 167 ++++++++++++++++
 tb/tb_wait_memory.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_memory.sv
// wait_memory: single-port 32-bit word memory with a fixed, parameterised
// response latency and a one-cycle ready strobe.
//
// A request is accepted in IDLE or RESP, optionally waits LATENCY cycles in
// WAIT, and completes with a one-cycle ready pulse. Writes use byte-lane
// strobes. The array access (read of the old word plus the byte-lane write)
// happens at the edge that raises ready. Out-of-range word indices complete
// normally with error=1 and read data 0.
//
// Optional feature: define WAIT_MEMORY_STATS_EN to add the read_count and
// write_count outputs (completed-access counters, wrapping modulo 2^32).
module wait_memory #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:2] address,
    input  logic [31:0] memory_in,
    input  logic [3:0]  write_enable,
    output logic [31:0] memory_out,
    output logic        ready,
    output logic        error
`ifdef WAIT_MEMORY_STATS_EN
    ,
    output logic [31:0] read_count,
    output logic [31:0] write_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // Wait-counter load value; only meaningful when LATENCY is nonzero.
    localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  count;

    // Access captured at acceptance; inputs may change freely afterwards.
    logic [31:2] addr_reg;
    logic [31:0] data_reg;
    logic [3:0]  we_reg;

    logic [31:0] mem [DEPTH_WORDS];

    logic               accept;
    logic               finish_wait;
    logic               fire;
    logic               commit;
    logic [31:2]        sel_addr;
    logic [31:0]        sel_data;
    logic [3:0]         sel_we;
    logic [31:0]        sel_index;
    logic               in_range;
    logic [IDX_W-1:0]   idx;

    // Request acceptance, wait completion and the selected access operands.
    // With LATENCY=0 the access completes on its acceptance edge, so the
    // live inputs are used; otherwise the captured copy is used from WAIT.
    always_comb begin
        accept      = req && ((state == IDLE) || (state == RESP));
        finish_wait = (state == WAIT) && (count == 4'd0);
        fire        = (LATENCY == 0) ? accept : finish_wait;

        if (state == WAIT) begin
            sel_addr = addr_reg;
            sel_data = data_reg;
            sel_we   = we_reg;
        end else begin
            sel_addr = address;
            sel_data = memory_in;
            sel_we   = write_enable;
        end

        sel_index = {2'b00, sel_addr};
        in_range  = sel_index < 32'(DEPTH_WORDS);
        idx       = sel_addr[IDX_W+1:2];
        // An access cut short by reset must never reach the array.
        commit    = fire && in_range && !rst;
    end

    // Control FSM with registered ready/error strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            ready    <= 1'b0;
            error    <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
            we_reg   <= '0;
        end else begin
            ready <= fire;
            error <= fire && !in_range;

            case (state)
                IDLE, RESP: begin
                    if (req) begin
                        addr_reg <= address;
                        data_reg <= memory_in;
                        we_reg   <= write_enable;
                        count    <= LAT_LOAD;
                        state    <= (LATENCY == 0) ? RESP : WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    // New requests are ignored here; the requester retries.
                    if (count == 4'd0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane write into the array at the completing edge (no reset).
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_we[b]) begin
                    mem[idx][b*8 +: 8] <= sel_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read data: old word (read-first), zero when out of range,
    // held until the next completed access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memory_out <= 32'd0;
        end else if (fire) begin
            memory_out <= in_range ? mem[idx] : 32'd0;
        end
    end

`ifdef WAIT_MEMORY_STATS_EN
    // Completed-access counters, out-of-range accesses included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_count  <= 32'd0;
            write_count <= 32'd0;
        end else if (fire) begin
            if (sel_we == 4'd0) begin
                read_count <= read_count + 32'd1;
            end else begin
                write_count <= write_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wait_memory.sv
// Directed testbench for wait_memory. Three instances run side by side:
//   dut0: LATENCY=0, DEPTH_WORDS=4096
//   dut1: LATENCY=3, DEPTH_WORDS=4096
//   dut2: LATENCY=5, DEPTH_WORDS=16
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_wait_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          [3];
    logic        req          [3];
    logic [31:2] address      [3];
    logic [31:0] memory_in    [3];
    logic [3:0]  write_enable [3];
    logic [31:0] memory_out   [3];
    logic        ready        [3];
    logic        error        [3];
`ifdef WAIT_MEMORY_STATS_EN
    logic [31:0] read_count   [3];
    logic [31:0] write_count  [3];
    int          exp_rd       [3];
    int          exp_wr       [3];
`endif

    int checks   = 0;
    int failures = 0;

    wait_memory #(.DEPTH_WORDS(4096), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .address(address[0]),
        .memory_in(memory_in[0]), .write_enable(write_enable[0]),
        .memory_out(memory_out[0]), .ready(ready[0]), .error(error[0])
`ifdef WAIT_MEMORY_STATS_EN
        , .read_count(read_count[0]), .write_count(write_count[0])
`endif
    );

    wait_memory #(.DEPTH_WORDS(4096), .LATENCY(3)) dut1 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .address(address[1]),
        .memory_in(memory_in[1]), .write_enable(write_enable[1]),
        .memory_out(memory_out[1]), .ready(ready[1]), .error(error[1])
`ifdef WAIT_MEMORY_STATS_EN
        , .read_count(read_count[1]), .write_count(write_count[1])
`endif
    );

    wait_memory #(.DEPTH_WORDS(16), .LATENCY(5)) dut2 (
        .clk(clk), .rst(rst[2]), .req(req[2]), .address(address[2]),
        .memory_in(memory_in[2]), .write_enable(write_enable[2]),
        .memory_out(memory_out[2]), .ready(ready[2]), .error(error[2])
`ifdef WAIT_MEMORY_STATS_EN
        , .read_count(read_count[2]), .write_count(write_count[2])
`endif
    );

    // Back-to-back operation table for dut1 (3 reads, 2 writes).
    logic [31:0] op_addr [5];
    logic [31:0] op_data [5];
    logic [3:0]  op_we   [5];
    logic        op_chk  [5];
    logic [31:0] op_exp  [5];

    // Watchdog: the directed sequence is short; never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tally(input int k, input logic [3:0] we);
`ifdef WAIT_MEMORY_STATS_EN
        if (we == 4'd0) exp_rd[k]++;
        else exp_wr[k]++;
`else
        if (k < 0 && we == 4'd0) $display("unused");
`endif
    endtask

    // One complete access, called at a falling edge. Checks ready stays low
    // during the wait cycles, then checks the response cycle. Inputs are
    // scrambled after acceptance; 'pulse' raises req during WAIT.
    task automatic access(input int k, input int lat, input logic [31:0] baddr,
                          input logic [31:0] data, input logic [3:0] we,
                          input logic pulse, input logic chk_data,
                          input logic [31:0] exp_data, input logic exp_err);
        address[k]      = baddr[31:2];
        memory_in[k]    = data;
        write_enable[k] = we;
        req[k]          = 1'b1;
        @(posedge clk);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check($sformatf("dut%0d_wait_ready_low_%0d", k, i), 32'(ready[k]), 32'd0);
            if (i == 0) begin
                address[k]      = ~baddr[31:2];
                memory_in[k]    = ~data;
                write_enable[k] = 4'hF;
                req[k]          = pulse;
            end else begin
                req[k] = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        req[k]          = 1'b0;
        address[k]      = ~baddr[31:2];
        memory_in[k]    = ~data;
        write_enable[k] = 4'hF;
        check($sformatf("dut%0d_ready_%h", k, baddr), 32'(ready[k]), 32'd1);
        check($sformatf("dut%0d_error_%h", k, baddr), 32'(error[k]), 32'(exp_err));
        if (chk_data)
            check($sformatf("dut%0d_data_%h", k, baddr), memory_out[k], exp_data);
        tally(k, we);
        $display("txn dut%0d %s addr=%h we=%b out=%h err=%0b",
                 k, (we == 4'd0) ? "RD" : "WR", baddr, we, memory_out[k], error[k]);
    endtask

    // Ready must drop after the response cycle when no new request follows.
    task automatic idle_check(input int k);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("dut%0d_ready_drop", k), 32'(ready[k]), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]          = 1'b1;
            req[k]          = 1'b0;
            address[k]      = '0;
            memory_in[k]    = '0;
            write_enable[k] = '0;
`ifdef WAIT_MEMORY_STATS_EN
            exp_rd[k] = 0;
            exp_wr[k] = 0;
`endif
        end
        op_addr = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100};
        op_data = '{32'hA5A5_0001, 32'h0, 32'h0000_00FF, 32'h0, 32'h0};
        op_we   = '{4'hF, 4'h0, 4'h1, 4'h0, 4'h0};
        op_chk  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        op_exp  = '{32'h0, 32'hA5A5_0001, 32'hA5A5_0001, 32'hA5A5_00FF, 32'hA5A5_00FF};

        // Reset state.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d_reset_ready", k), 32'(ready[k]), 32'd0);
            check($sformatf("dut%0d_reset_error", k), 32'(error[k]), 32'd0);
            check($sformatf("dut%0d_reset_out", k), memory_out[k], 32'd0);
            rst[k] = 1'b0;
        end

        // LATENCY=0: write then read 0x40 (first request on first edge).
        access(0, 0, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        access(0, 0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        idle_check(0);

        // LATENCY=3: byte lanes, req pulses during WAIT ignored.
        access(1, 3, 32'h200, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        access(1, 3, 32'h200, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b1, 32'h1122_3344, 1'b0);
        access(1, 3, 32'h200, 32'h0, 4'h0, 1'b1, 1'b1, 32'h11BB_33DD, 1'b0);
        idle_check(1);

        // DEPTH_WORDS=16, LATENCY=5: range boundary and out-of-range.
        access(2, 5, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        access(2, 5, 32'h3C, 32'h0F0F_0F0F, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
        access(2, 5, 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0, 1'b1);
        access(2, 5, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        access(2, 5, 32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        access(2, 5, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        access(2, 5, 32'h3C, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0F0F_0F0F, 1'b0);
        idle_check(2);

        // LATENCY=5: reset two cycles after accepting a write aborts it.
        address[2]      = 30'h0;
        memory_in[2]    = 32'h1234_5678;
        write_enable[2] = 4'hF;
        req[2]          = 1'b1;
        @(posedge clk);                 // acceptance edge N
        @(negedge clk);
        req[2] = 1'b0;
        @(posedge clk);                 // N+1
        @(posedge clk);                 // N+2
        @(negedge clk);
        rst[2] = 1'b1;
        #1;
        check("dut2_async_reset_out", memory_out[2], 32'd0);
        check("dut2_async_reset_ready", 32'(ready[2]), 32'd0);
`ifdef WAIT_MEMORY_STATS_EN
        exp_rd[2] = 0;
        exp_wr[2] = 0;
`endif
        @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("dut2_abort_no_ready_%0d", i), 32'(ready[2]), 32'd0);
        end
        access(2, 5, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        idle_check(2);

        // LATENCY=3 back-to-back with req held high: responses every 4 cycles.
        address[1]      = op_addr[0][31:2];
        memory_in[1]    = op_data[0];
        write_enable[1] = op_we[0];
        req[1]          = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 5 * 4; c++) begin
            @(negedge clk);
            if (c % 4 == 0) begin
                if (c / 4 + 1 < 5) begin
                    address[1]      = op_addr[c/4+1][31:2];
                    memory_in[1]    = op_data[c/4+1];
                    write_enable[1] = op_we[c/4+1];
                end else begin
                    req[1] = 1'b0;
                end
            end
            check($sformatf("dut1_b2b_ready_c%0d", c), 32'(ready[1]), 32'((c % 4) == 3));
            if (c % 4 == 3) begin
                check($sformatf("dut1_b2b_error_op%0d", c / 4), 32'(error[1]), 32'd0);
                if (op_chk[c/4])
                    check($sformatf("dut1_b2b_data_op%0d", c / 4), memory_out[1], op_exp[c/4]);
                tally(1, op_we[c/4]);
                $display("txn dut1 b2b op%0d out=%h", c / 4, memory_out[1]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("dut1_b2b_ready_drop", 32'(ready[1]), 32'd0);

`ifdef WAIT_MEMORY_STATS_EN
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d_read_count", k), read_count[k], 32'(exp_rd[k]));
            check($sformatf("dut%0d_write_count", k), write_count[k], 32'(exp_wr[k]));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
